param_stack: RTL and testbench
==============================

# param_stack

Parametrised synchronous LIFO stack, the next generation of the team's fixed 8-bit stack. Width and depth are set by parameters. Exposes a registered top-of-stack view, occupancy count, full/empty status, sticky overflow/underflow flags and a per-cycle error pulse. Supports an atomic replace-top operation when push and pop are asserted together. Used as operand/return storage in datapath blocks.

## Interface
- WIDTH, 8, data word width in bits (>= 1)
- DEPTH, 16, maximum number of stored entries (>= 2; need not be a power of two)
- CW (localparam), $clog2(DEPTH+1), width of count
- clk  input  1  single clock; all state changes on the rising edge
- reset_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk
- clear  input  1  synchronous flush: empties stack and clears sticky flags
- push  input  1  push data_in this cycle
- pop  input  1  discard top entry this cycle
- data_in  input  WIDTH  word to push
- data_out  output  WIDTH  registered current top of stack; 0 when empty
- count  output  CW  number of stored entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky: push attempted while full (without pop)
- underflow  output  1  sticky: pop attempted while empty (without push)
- error  output  1  one-cycle pulse for a cycle that set overflow or underflow

## Operation
- Storage: DEPTH-entry memory plus stack pointer. data_out is a dedicated register holding the top entry.
- Priority each edge: reset_n low > clear > push/pop decode.
- clear: count <= 0, data_out <= 0, overflow/underflow <= 0, error <= 0. Push/pop in the same cycle are ignored. Memory contents are don't-care.
- Decode when not clearing:
  - idle (push=0, pop=0): no change; error <= 0.
  - push only, not full: entry stored, count+1, data_out <= data_in.
  - push only, full: no state change; overflow <= 1; error pulses.
  - pop only, count >= 2: count-1; data_out <= new top, the entry pushed before the discarded one.
  - pop only, count == 1: count <= 0, data_out <= 0.
  - pop only, empty: no state change; underflow <= 1; error pulses.
  - push and pop, count >= 1 (including full): replace top. data_out <= data_in, count unchanged, no flag set.
  - push and pop, empty: treated as push only. count <= 1, data_out <= data_in, no underflow.
- Sticky flags hold until clear or reset. error is high only in the cycle after an offending edge.
- The stack contents beneath the top entry are preserved exactly across any mix of legal operations.
- count arithmetic is unsigned CW-bit. It never wraps: saturation is enforced by the full/empty checks above.

## Timing
- Reset (reset_n low, asynchronous): data_out=0, count=0, empty=1, full=0, overflow=0, underflow=0, error=0.
- All outputs are registered. An operation sampled at edge N is visible on all outputs immediately after edge N, giving 1-cycle latency. No combinational path from inputs to outputs.
- Back-to-back operations are permitted every cycle with no bubbles. Pop immediately after push returns the previous top the next cycle.
- empty/full are derived from registered count and are coherent with count in the same cycle.
- reset_n asserted mid-operation aborts the in-flight operation. Outputs go to reset values without waiting for clk.

## Test plan
- Reset, then 16 pushes alternating 8'hAA/8'h55 (WIDTH=8, DEPTH=16) -> count steps 1..16; data_out tracks last pushed value; full=1 after the 16th; error never pulses.
- While full, push 8'hFF -> count stays 16, data_out stays 8'h55, overflow=1 (sticky), error high for exactly one cycle.
- 16 pops from full -> data_out sequence 8'hAA, 8'h55, ... ending 0; count 15..0; empty=1. A 17th pop -> underflow=1, error one-cycle pulse, count stays 0.
- Push 8'h11, 8'h22, then push+pop with 8'h33 -> count=2, data_out=8'h33. Pop -> data_out=8'h11. Push+pop on empty with 8'h44 -> count=1, data_out=8'h44, no underflow.
- With overflow/underflow set and count=5, assert clear together with push -> count=0, data_out=0, both flags 0, push ignored.
- Assert reset_n low between clock edges during a push burst -> all outputs reach reset values before the next edge. After release, a push of 8'h5A gives count=1, data_out=8'h5A.

Source files
------------

// File: rtl/param_stack.sv
// Parametrised synchronous LIFO stack with a registered top-of-stack view,
// occupancy count, full/empty status, sticky overflow/underflow flags and error pulse.
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             error
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] data_r;
    logic [CW-1:0]    count_r;
    logic             empty_r;
    logic             full_r;
    logic             ovf_r;
    logic             unf_r;
    logic             err_r;

    logic [WIDTH-1:0] data_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic             ovf_nxt_s;
    logic             unf_nxt_s;
    logic             err_nxt_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_addr_s;
    logic [AW-1:0]    rd_addr_s;
    logic [WIDTH-1:0] below_top_s;
    logic             is_full_s;
    logic             is_empty_s;

    // Entry beneath the top, only meaningful while two or more entries are stored.
    assign rd_addr_s   = AW'(count_r - CW'(2));
    assign below_top_s = mem_r[rd_addr_s];
    assign is_full_s   = (count_r == CW'(DEPTH));
    assign is_empty_s  = (count_r == {CW{1'b0}});

    // Next-state decode: clear dominates, then the push/pop combination.
    always_comb begin
        data_nxt_s  = data_r;
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        unf_nxt_s   = unf_r;
        err_nxt_s   = 1'b0;
        wr_en_s     = 1'b0;
        wr_addr_s   = AW'(count_r);
        if (clear) begin
            data_nxt_s  = {WIDTH{1'b0}};
            count_nxt_s = {CW{1'b0}};
            ovf_nxt_s   = 1'b0;
            unf_nxt_s   = 1'b0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    // Replace-top overwrites the current top slot; on empty it acts as a push.
                    wr_en_s    = 1'b1;
                    data_nxt_s = data_in;
                    if (is_empty_s) begin
                        wr_addr_s   = {AW{1'b0}};
                        count_nxt_s = CW'(1);
                    end else begin
                        wr_addr_s   = AW'(count_r - CW'(1));
                    end
                end
                2'b10: begin
                    if (is_full_s) begin
                        ovf_nxt_s = 1'b1;
                        err_nxt_s = 1'b1;
                    end else begin
                        wr_en_s     = 1'b1;
                        count_nxt_s = count_r + CW'(1);
                        data_nxt_s  = data_in;
                    end
                end
                2'b01: begin
                    if (is_empty_s) begin
                        unf_nxt_s = 1'b1;
                        err_nxt_s = 1'b1;
                    end else if (count_r == CW'(1)) begin
                        count_nxt_s = {CW{1'b0}};
                        data_nxt_s  = {WIDTH{1'b0}};
                    end else begin
                        count_nxt_s = count_r - CW'(1);
                        data_nxt_s  = below_top_s;
                    end
                end
                default: begin
                    err_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Status and top-of-stack registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r  <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            data_r  <= data_nxt_s;
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == {CW{1'b0}});
            full_r  <= (count_nxt_s == CW'(DEPTH));
            ovf_r   <= ovf_nxt_s;
            unf_r   <= unf_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Storage array; contents are don't-care after reset or clear.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= data_in;
        end
    end

    assign data_out  = data_r;
    assign count     = count_r;
    assign empty     = empty_r;
    assign full      = full_r;
    assign overflow  = ovf_r;
    assign underflow = unf_r;
    assign error     = err_r;

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: queue-based reference model, per-cycle
// compare process, directed literal checks and randomized traffic.
module tb_param_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic             error;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    bit m_err = 1'b0;
    bit check_en = 1'b0;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .push(push), .pop(pop),
        .data_in(data_in), .data_out(data_out), .count(count), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_top();
        if (q.size() == 0) return 8'h00;
        return q[q.size()-1];
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit c, input bit pu, input bit po, input logic [WIDTH-1:0] d);
        m_err = 1'b0;
        if (c) begin
            model_reset();
        end else if (pu && po) begin
            if (q.size() == 0) q.push_back(d);
            else q[q.size()-1] = d;
        end else if (pu) begin
            if (q.size() == DEPTH) begin
                m_ovf = 1'b1;
                m_err = 1'b1;
            end else begin
                q.push_back(d);
            end
        end else if (po) begin
            if (q.size() == 0) begin
                m_unf = 1'b1;
                m_err = 1'b1;
            end else begin
                void'(q.pop_back());
            end
        end
    endtask

    // Drive one cycle, advance the model at the edge, then settle just after it.
    task automatic op(input bit c, input bit pu, input bit po, input logic [WIDTH-1:0] d);
        clear = c; push = pu; pop = po; data_in = d;
        @(posedge clk);
        model_step(c, pu, po, d);
        #1;
        clear = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("data_out", 32'(data_out), 32'(exp_top()));
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
            chk("error", 32'(error), 32'(m_err));
        end
    end

    initial begin
        int bias;
        reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_flags", 32'({overflow, underflow, error}), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        check_en = 1'b1;

        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 1'b0, (i % 2 == 1) ? 8'h55 : 8'hAA);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_error", 32'(error), 32'h0);
        end
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_top", 32'(data_out), 32'h55);

        op(1'b0, 1'b1, 1'b0, 8'hFF);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_top", 32'(data_out), 32'h55);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_error", 32'(error), 32'h1);
        op(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovf_error_pulse", 32'(error), 32'h0);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_count", 32'(count), 32'(15 - i));
            chk("drain_top", 32'(data_out),
                (i == 15) ? 32'h0 : (((14 - i) % 2 == 1) ? 32'h55 : 32'hAA));
        end
        chk("drain_empty", 32'(empty), 32'h1);
        op(1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf_flag", 32'(underflow), 32'h1);
        chk("unf_error", 32'(error), 32'h1);
        chk("unf_count", 32'(count), 32'h0);
        op(1'b0, 1'b0, 1'b0, 8'h00);
        chk("unf_error_pulse", 32'(error), 32'h0);

        op(1'b0, 1'b1, 1'b0, 8'h11);
        op(1'b0, 1'b1, 1'b0, 8'h22);
        op(1'b0, 1'b1, 1'b1, 8'h33);
        chk("repl_count", 32'(count), 32'd2);
        chk("repl_top", 32'(data_out), 32'h33);
        op(1'b0, 1'b0, 1'b1, 8'h00);
        chk("repl_pop_top", 32'(data_out), 32'h11);
        op(1'b0, 1'b0, 1'b1, 8'h00);
        op(1'b0, 1'b1, 1'b1, 8'h44);
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_top", 32'(data_out), 32'h44);
        chk("pp_empty_error", 32'(error), 32'h0);

        for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 1'b0, 8'(i + 1));
        chk("pre_clr_count", 32'(count), 32'd5);
        chk("pre_clr_flags", 32'({overflow, underflow}), 32'h3);
        op(1'b1, 1'b1, 1'b0, 8'h77);
        chk("clr_count", 32'(count), 32'h0);
        chk("clr_top", 32'(data_out), 32'h0);
        chk("clr_flags", 32'({overflow, underflow, error}), 32'h0);

        bias = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(2))
                    0: bias = 20;
                    1: bias = 50;
                    default: bias = 85;
                endcase
            end
            op($urandom_range(199) == 0,
               $urandom_range(99) < bias,
               $urandom_range(99) < (100 - bias),
               8'($urandom));
        end

        op(1'b0, 1'b1, 1'b0, 8'hC1);
        op(1'b0, 1'b1, 1'b0, 8'hC2);
        push = 1'b1; data_in = 8'hAB;
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_count", 32'(count), 32'h0);
        chk("async_rst_top", 32'(data_out), 32'h0);
        chk("async_rst_status", 32'({empty, full, overflow, underflow, error}), 32'h10);
        push = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        op(1'b0, 1'b1, 1'b0, 8'h5A);
        chk("post_rst_count", 32'(count), 32'd1);
        chk("post_rst_top", 32'(data_out), 32'h5A);

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
